// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard query bus: producer info and operand queries in, stall and forward selects out.
// Latency: none, pure signal bundle.
// Backpressure: stall is the only backpressure; the master must hold PC and F/D while it is high.
// Optional HAZARD_SCOREBOARD_STATS_EN adds the stall_cnt and raw_hit_cnt observation counters.
interface hazard_scoreboard_if #(
   parameter int TNEW_W = 2,
   parameter int REG_W  = 5
);
   logic              flush_E;
   logic              wr_en_D;
   logic [REG_W-1:0]  wr_addr_D;
   logic [TNEW_W-1:0] tnew_D;
   logic [REG_W-1:0]  rs_D;
   logic [REG_W-1:0]  rt_D;
   logic              use_rs_D;
   logic              use_rt_D;
   logic [TNEW_W-1:0] tuse_rs_D;
   logic [TNEW_W-1:0] tuse_rt_D;
   logic              stall;
   logic [1:0]        fwd_rs_D;
   logic [1:0]        fwd_rt_D;
`ifdef HAZARD_SCOREBOARD_STATS_EN
   logic [31:0]       stall_cnt;
   logic [31:0]       raw_hit_cnt;
`endif

   // Decode stage drives producer and query fields and consumes the verdict
   modport master (
      output flush_E, wr_en_D, wr_addr_D, tnew_D, rs_D, rt_D,
             use_rs_D, use_rt_D, tuse_rs_D, tuse_rt_D,
      input  stall, fwd_rs_D, fwd_rt_D
`ifdef HAZARD_SCOREBOARD_STATS_EN
      , input stall_cnt, raw_hit_cnt
`endif
   );

   // Scoreboard side
   modport slave (
      input  flush_E, wr_en_D, wr_addr_D, tnew_D, rs_D, rt_D,
             use_rs_D, use_rt_D, tuse_rs_D, tuse_rt_D,
      output stall, fwd_rs_D, fwd_rt_D
`ifdef HAZARD_SCOREBOARD_STATS_EN
      , output stall_cnt, raw_hit_cnt
`endif
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks destination/Tnew of instructions in E/M/W and resolves D-stage rs/rt hazards into stall + forward codes.
// Latency: stall and forward selects are combinational (zero cycles); the tracked entries advance every clock.
// Backpressure: asserts stall (bubble into E) whenever the youngest producer of a source is not ready by its Tuse.
// Optional HAZARD_SCOREBOARD_STATS_EN adds 32-bit wrapping stall-cycle and raw-hit-cycle counters.
module hazard_scoreboard #(
   parameter int TNEW_W = 2,
   parameter int REG_W  = 5
) (
   input  logic                clk,
   input  logic                reset,
   hazard_scoreboard_if.slave  bus
);

   typedef struct packed {
      logic              vld;
      logic [REG_W-1:0]  addr;
      logic [TNEW_W-1:0] tnew;
   } ent_t;

   ent_t ent_e_q, ent_e_d;
   ent_t ent_m_q, ent_m_d;
   ent_t ent_w_q, ent_w_d;

   logic       rs_stall, rt_stall;
   logic       rs_hit, rt_hit;
   logic [1:0] rs_fwd, rt_fwd;

   // Moving one stage down brings the result one cycle closer; never below zero
   function automatic ent_t advance(input ent_t e);
      ent_t r;
      r = e;
      if (e.tnew != '0) r.tnew = e.tnew - 1'b1;
      return r;
   endfunction

   // Youngest matching producer decides: {hit, stall, fwd}; $0 and unused sources never hit
   function automatic logic [3:0] resolve(input ent_t e, input ent_t m, input ent_t w,
                                          input logic [REG_W-1:0] src, input logic use_s,
                                          input logic [TNEW_W-1:0] tuse);
      logic [3:0] r;
      r = '0;
      if (use_s && src != '0) begin
         if (e.vld && e.addr == src)
            r = {1'b1, e.tnew > tuse, (e.tnew == '0) ? 2'd1 : 2'd0};
         else if (m.vld && m.addr == src)
            r = {1'b1, m.tnew > tuse, (m.tnew == '0) ? 2'd2 : 2'd0};
         else if (w.vld && w.addr == src)
            r = {1'b1, w.tnew > tuse, (w.tnew == '0) ? 2'd3 : 2'd0};
      end
      return r;
   endfunction

   // Per-source hazard resolution and combined stall
   always_comb begin
      {rs_hit, rs_stall, rs_fwd} = resolve(ent_e_q, ent_m_q, ent_w_q,
                                           bus.rs_D, bus.use_rs_D, bus.tuse_rs_D);
      {rt_hit, rt_stall, rt_fwd} = resolve(ent_e_q, ent_m_q, ent_w_q,
                                           bus.rt_D, bus.use_rt_D, bus.tuse_rt_D);
      bus.stall    = rs_stall | rt_stall;
      bus.fwd_rs_D = rs_fwd;
      bus.fwd_rt_D = rt_fwd;
   end

   // Next entries: shift E->M->W, load E from D or with a bubble on stall/flush
   always_comb begin
      ent_w_d = advance(ent_m_q);
      ent_m_d = advance(ent_e_q);
      ent_e_d = '0;
      if (!bus.stall && !bus.flush_E) begin
         ent_e_d.vld  = bus.wr_en_D && (bus.wr_addr_D != '0);
         ent_e_d.addr = bus.wr_addr_D;
         ent_e_d.tnew = bus.tnew_D;
      end
   end

   // Entry registers; reset overrides stall and flush
   always_ff @(posedge clk) begin
      if (reset) begin
         ent_e_q <= '0;
         ent_m_q <= '0;
         ent_w_q <= '0;
      end else begin
         ent_e_q <= ent_e_d;
         ent_m_q <= ent_m_d;
         ent_w_q <= ent_w_d;
      end
   end

`ifdef HAZARD_SCOREBOARD_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] raw_hit_cnt_q, raw_hit_cnt_d;

   // Count stall cycles and cycles with any producer match (wrap naturally)
   always_comb begin
      stall_cnt_d   = stall_cnt_q + {31'd0, bus.stall};
      raw_hit_cnt_d = raw_hit_cnt_q + {31'd0, rs_hit | rt_hit};
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q   <= '0;
         raw_hit_cnt_q <= '0;
      end else begin
         stall_cnt_q   <= stall_cnt_d;
         raw_hit_cnt_q <= raw_hit_cnt_d;
      end
   end

   assign bus.stall_cnt   = stall_cnt_q;
   assign bus.raw_hit_cnt = raw_hit_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic against an in-flight list model.
// Latency: outputs are sampled mid-cycle, after inputs settle and before the next rising edge.
// Backpressure: the model decides when D is stalled and only then withholds the E load.
`timescale 1ns/1ps
module tb_hazard_scoreboard;
   localparam int TNEW_W = 2;
   localparam int REG_W  = 5;

   logic clk = 1'b0;
   logic reset;

   hazard_scoreboard_if #(.TNEW_W(TNEW_W), .REG_W(REG_W)) bus ();

   hazard_scoreboard #(.TNEW_W(TNEW_W), .REG_W(REG_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: list of issued producers stamped with the cycle they entered E.
   typedef struct {
      int addr;
      int tnew;
      int born;
   } inst_t;

   inst_t flight[$];
   int    cyc = 0;
   int    m_stall_cnt = 0;
   int    m_hit_cnt = 0;

   logic       obs_stall;
   logic [1:0] obs_frs, obs_frt;

   // Youngest producer of src (smallest age); remaining wait = tnew - age, floored at 0
   function automatic void query(input int src, input int use_s, input int tuse,
                                 output int st, output int fw, output int hit);
      int best_age;
      int best_rem;
      best_age = 99;
      best_rem = 0;
      st = 0; fw = 0; hit = 0;
      if (use_s != 0 && src != 0) begin
         foreach (flight[i]) begin
            int age;
            age = cyc - flight[i].born;
            if (flight[i].addr == src && age >= 0 && age <= 2 && age < best_age) begin
               best_age = age;
               best_rem = (flight[i].tnew > age) ? flight[i].tnew - age : 0;
            end
         end
         if (best_age != 99) begin
            hit = 1;
            st  = (best_rem > tuse) ? 1 : 0;
            fw  = (best_rem == 0) ? best_age + 1 : 0;
         end
      end
   endfunction

   task automatic cycle(input bit rst, input bit fl, input bit we, input int wa, input int tn,
                        input int rs, input int rt, input int urs, input int urt,
                        input int tus, input int tut);
      int s1, f1, h1, s2, f2, h2, es;
      reset         = rst;
      bus.flush_E   = fl;
      bus.wr_en_D   = we;
      bus.wr_addr_D = wa[REG_W-1:0];
      bus.tnew_D    = tn[TNEW_W-1:0];
      bus.rs_D      = rs[REG_W-1:0];
      bus.rt_D      = rt[REG_W-1:0];
      bus.use_rs_D  = (urs != 0);
      bus.use_rt_D  = (urt != 0);
      bus.tuse_rs_D = tus[TNEW_W-1:0];
      bus.tuse_rt_D = tut[TNEW_W-1:0];
      #2;
      query(rs, urs, tus, s1, f1, h1);
      query(rt, urt, tut, s2, f2, h2);
      es = s1 | s2;
      obs_stall = bus.stall;
      obs_frs   = bus.fwd_rs_D;
      obs_frt   = bus.fwd_rt_D;
      chk("stall",  {31'd0, bus.stall}, es);
      chk("fwd_rs", {30'd0, bus.fwd_rs_D}, f1);
      chk("fwd_rt", {30'd0, bus.fwd_rt_D}, f2);
`ifdef HAZARD_SCOREBOARD_STATS_EN
      chk("stall_cnt",   bus.stall_cnt, m_stall_cnt);
      chk("raw_hit_cnt", bus.raw_hit_cnt, m_hit_cnt);
`endif
      @(posedge clk);
      if (rst) begin
         flight.delete();
         m_stall_cnt = 0;
         m_hit_cnt   = 0;
      end else begin
         m_stall_cnt += es;
         m_hit_cnt   += (h1 | h2);
         if (es == 0 && !fl && we && wa != 0)
            flight.push_back('{addr: wa, tnew: tn, born: cyc + 1});
      end
      cyc++;
      for (int i = flight.size() - 1; i >= 0; i--)
         if (cyc - flight[i].born > 2) flight.delete(i);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // Bring flops out of X before anything is compared
      reset = 1'b1;
      bus.flush_E = 0; bus.wr_en_D = 0; bus.wr_addr_D = '0; bus.tnew_D = '0;
      bus.rs_D = '0; bus.rt_D = '0; bus.use_rs_D = 0; bus.use_rt_D = 0;
      bus.tuse_rs_D = '0; bus.tuse_rt_D = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state: a live query sees nothing
      cycle(0, 0, 0, 0, 0, 8, 8, 1, 1, 0, 0);
      chk("rst_stall", {31'd0, obs_stall}, 0);
      chk("rst_fwd_rs", {30'd0, obs_frs}, 0);

      // Load-use: lw $8 then addu using $8
      cycle(0, 0, 1, 8, 2, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 1, 10, 1, 8, 0, 1, 0, 1, 0);
      chk("lu_stall", {31'd0, obs_stall}, 1);
      cycle(0, 0, 1, 10, 1, 8, 0, 1, 0, 1, 0);
      chk("lu_release", {31'd0, obs_stall}, 0);
      idle(3);

      // ALU back-to-back on rt
      cycle(0, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 1, 11, 1, 0, 9, 0, 1, 0, 1);
      chk("alu_stall", {31'd0, obs_stall}, 0);
      cycle(0, 0, 0, 0, 0, 0, 9, 0, 1, 0, 1);
      chk("alu_fwd_m", {30'd0, obs_frt}, 2);
      idle(3);

      // Branch after ALU
      cycle(0, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 4, 0, 1, 0, 0, 0);
      chk("br_stall", {31'd0, obs_stall}, 1);
      cycle(0, 0, 0, 0, 0, 4, 0, 1, 0, 0, 0);
      chk("br_fwd_m", {30'd0, obs_frs}, 2);
      idle(3);

      // jal then jr $31
      cycle(0, 0, 1, 31, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 31, 0, 1, 0, 0, 0);
      chk("jr_fwd_e", {30'd0, obs_frs}, 1);
      chk("jr_stall", {31'd0, obs_stall}, 0);
      idle(3);

      // Younger not-ready producer shadows a ready older one; rs==rt agree
      cycle(0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 5, 5, 1, 1, 1, 1);
      chk("prio_fwd_rs", {30'd0, obs_frs}, 0);
      chk("prio_fwd_rt", {30'd0, obs_frt}, 0);
      chk("prio_stall", {31'd0, obs_stall}, 0);
      idle(3);

      // Writes to $0 never create a producer
      cycle(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      chk("r0_fwd", {30'd0, obs_frs}, 0);
      idle(3);

      // Flushed producer is a bubble
      cycle(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 7, 0, 1, 0, 1, 0);
      chk("flush_fwd", {30'd0, obs_frs}, 0);
      idle(3);

      // Reset while stalling
      cycle(0, 0, 1, 8, 2, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 1, 10, 1, 8, 0, 1, 0, 1, 0);
      chk("rs_mid_stall", {31'd0, obs_stall}, 1);
      cycle(0, 0, 1, 10, 1, 8, 0, 1, 0, 1, 0);
      chk("rs_after_stall", {31'd0, obs_stall}, 0);
      chk("rs_after_fwd", {30'd0, obs_frs}, 0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
      chk("rs_after_cnt", bus.stall_cnt, 0);
`endif

      // Random traffic on a small register window to force frequent matches
      for (int n = 0; n < 600; n++) begin
         int t;
         t = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
         cycle($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) < 7, $urandom_range(0, 4), t,
               $urandom_range(0, 4), $urandom_range(0, 4),
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 2), $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
